// File: rtl/pm_byte_loader.sv
// Program-memory byte loader: takes 32-bit words over valid/ready and writes
// them as four little-endian byte writes at auto-incrementing addresses.
module pm_byte_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 7,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH-1:0]  base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_word,
  input  logic                  in_last,
  output logic                  pmWrEn,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [WIDTH-1:0]      instructionIn,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap_err
);

  // state | meaning
  // IDLE  | waiting for start
  // WAIT  | in_ready high, waiting for a word handshake
  // SEND  | four byte writes of the latched word
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_t;

  localparam logic [ADD_WIDTH-1:0] ADDR_MAX = '1;

  state_t                state_q, state_d;
  logic [ADD_WIDTH-1:0]  addr_q, addr_d;
  logic [ADD_WIDTH-1:0]  pm_addr_q, pm_addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0]      instr_q, instr_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic                  last_q, last_d;
  logic                  in_ready_q, in_ready_d;
  logic                  pm_wr_en_q, pm_wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap_err_q, wrap_err_d;
  logic                  issue;
  logic [WIDTH-1:0]      issue_byte;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pm_addr_d  = pm_addr_q;
    word_d     = word_q;
    instr_d    = instr_q;
    byte_cnt_d = byte_cnt_q;
    last_d     = last_q;
    in_ready_d = in_ready_q;
    pm_wr_en_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_err_d = wrap_err_q;
    issue      = 1'b0;
    issue_byte = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = {base_addr[ADD_WIDTH-1:2], 2'b00};
          wrap_err_d = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          last_d     = in_last;
          word_d     = in_word >> WIDTH;
          issue      = 1'b1;
          issue_byte = in_word[WIDTH-1:0];
          byte_cnt_d = 2'd3;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        // Byte 0 was issued on the handshake; the counter tracks bytes still to issue.
        if (byte_cnt_q == 2'd0) begin
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            in_ready_d = 1'b1;
            state_d    = S_WAIT;
          end
        end else begin
          issue      = 1'b1;
          issue_byte = word_q[WIDTH-1:0];
          word_d     = word_q >> WIDTH;
          byte_cnt_d = byte_cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      pm_wr_en_d = 1'b1;
      pm_addr_d  = addr_q;
      instr_d    = issue_byte;
      addr_d     = addr_q + 1'b1;
      if (addr_q == ADDR_MAX) wrap_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pm_addr_q  <= '0;
      word_q     <= '0;
      instr_q    <= '0;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      pm_wr_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pm_addr_q  <= pm_addr_d;
      word_q     <= word_d;
      instr_q    <= instr_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      pm_wr_en_q <= pm_wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_err_q <= wrap_err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign pmWrEn        = pm_wr_en_q;
  assign pm_addr       = pm_addr_q;
  assign instructionIn = instr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wrap_err      = wrap_err_q;

endmodule
